// File: rtl/seq_booth_mult.sv
// seq_booth_mult: iterative multiplier, one add/sub-and-shift step per clock.
// Macro BOOTH_SIGNED_EN selects radix-2 Booth (signed); default is unsigned.
module seq_booth_mult #(
    parameter int WIDTH = 8
) (
    input  logic               CLK,
    input  logic               RST_N,
    input  logic               START,
    input  logic [WIDTH-1:0]   A,
    input  logic [WIDTH-1:0]   B,
    output logic               BUSY,
    output logic               DONE,
    output logic [2*WIDTH-1:0] P
);

    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE_S
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   m_q, m_d;
    logic [WIDTH:0]     acc_q, acc_d;
    logic [WIDTH-1:0]   q_q, q_d;
    logic               q1_q, q1_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [2*WIDTH-1:0] p_q, p_d;

    logic [WIDTH:0]     mext;
    logic [WIDTH:0]     sum;
    logic [WIDTH:0]     sh_acc;
    logic [WIDTH-1:0]   sh_q;
    logic               sh_q1;

    // One arithmetic step followed by the right shift of {ACC,Q,Q_1}
    always_comb begin
        sum = acc_q;
`ifdef BOOTH_SIGNED_EN
        mext = {m_q[WIDTH-1], m_q};
        unique case ({q_q[0], q1_q})
            2'b01:   sum = acc_q + mext;
            2'b10:   sum = acc_q - mext;
            default: sum = acc_q;
        endcase
        sh_acc = {sum[WIDTH], sum[WIDTH:1]};
        sh_q1  = q_q[0];
`else
        mext = {1'b0, m_q};
        if (q_q[0]) begin
            sum = acc_q + mext;
        end
        sh_acc = {1'b0, sum[WIDTH:1]};
        sh_q1  = 1'b0;
`endif
        sh_q = {sum[0], q_q[WIDTH-1:1]};
    end

    // Next-state and datapath register updates
    always_comb begin
        state_d = state_q;
        m_d     = m_q;
        acc_d   = acc_q;
        q_d     = q_q;
        q1_d    = q1_q;
        cnt_d   = cnt_q;
        p_d     = p_q;
        unique case (state_q)
            IDLE: begin
                if (START) begin
                    m_d     = A;
                    q_d     = B;
                    acc_d   = '0;
                    q1_d    = 1'b0;
                    cnt_d   = CW'(WIDTH);
                    state_d = RUN;
                end
            end
            RUN: begin
                acc_d = sh_acc;
                q_d   = sh_q;
                q1_d  = sh_q1;
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    p_d     = {sh_acc[WIDTH-1:0], sh_q};
                    state_d = DONE_S;
                end
            end
            DONE_S: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath flops, synchronous active-low clear
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_q <= IDLE;
            m_q     <= '0;
            acc_q   <= '0;
            q_q     <= '0;
            q1_q    <= 1'b0;
            cnt_q   <= '0;
            p_q     <= '0;
        end else begin
            state_q <= state_d;
            m_q     <= m_d;
            acc_q   <= acc_d;
            q_q     <= q_d;
            q1_q    <= q1_d;
            cnt_q   <= cnt_d;
            p_q     <= p_d;
        end
    end

    // Status decoded straight from the state register
    always_comb begin
        BUSY = (state_q == RUN);
        DONE = (state_q == DONE_S);
        P    = p_q;
    end

endmodule
